// File: rtl/pulp_sync_debounce.sv
// Stability filter for an already-synchronised serial level.
// A new level is accepted only after STABLE_CYCLES consecutive enabled samples.
// On acceptance it updates the filtered level, emits a one-cycle edge pulse,
// counts rising edges (saturating) and offers the edge in a one-entry event slot
// with a valid/ready handshake.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   en_i           sample strobe; serial_i is evaluated only when high
//   serial_i       synchronised input level
//   clr_i          clears edge_cnt_o, evt_overflow_o (and glitch_cnt_o)
//   filt_o         filtered level
//   r_edge_o       one-cycle pulse on accepted 0->1
//   f_edge_o       one-cycle pulse on accepted 1->0
//   edge_cnt_o     accepted rising edges, saturating
//   evt_valid_o    event slot occupied
//   evt_ready_i    consumer pops the event
//   evt_rise_o     event direction (1 = rising), meaningful while evt_valid_o
//   evt_overflow_o sticky: an event was dropped because the slot was full
//   glitch_cnt_o   aborted checks, saturating (only with PULP_DEBOUNCE_GLITCH_CNT_EN)
//
// Optional feature macro: PULP_DEBOUNCE_GLITCH_CNT_EN adds glitch_cnt_o.

module pulp_sync_debounce #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 serial_i,
  input  logic                 clr_i,
  output logic                 filt_o,
  output logic                 r_edge_o,
  output logic                 f_edge_o,
  output logic [CNT_WIDTH-1:0] edge_cnt_o,
`ifdef PULP_DEBOUNCE_GLITCH_CNT_EN
  output logic [CNT_WIDTH-1:0] glitch_cnt_o,
`endif
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic                 evt_rise_o,
  output logic                 evt_overflow_o
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdleLow, StChkHigh, StIdleHigh, StChkLow} state_e;

  localparam state_e ResetState = RESET_LEVEL ? StIdleHigh : StIdleLow;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            acc_rise, acc_fall, abort;

  logic                 filt_q, filt_d;
  logic                 r_edge_q, f_edge_q;
  logic [CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic                 evt_valid_q, evt_valid_d;
  logic                 evt_rise_q, evt_rise_d;
  logic                 evt_ovf_q, evt_ovf_d;

  // Next-state logic of the stability filter
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_rise = 1'b0;
    acc_fall = 1'b0;
    abort    = 1'b0;
    if (en_i) begin
      unique case (state_q)
        StIdleLow: begin
          if (serial_i) begin
            if (STABLE_CYCLES == 1) begin
              state_d  = StIdleHigh;
              acc_rise = 1'b1;
            end else begin
              state_d = StChkHigh;
              cnt_d   = CntOne;
            end
          end
        end
        StChkHigh: begin
          if (!serial_i) begin
            state_d = StIdleLow;
            cnt_d   = '0;
            abort   = 1'b1;
          end else if (cnt_q == CntLast) begin
            state_d  = StIdleHigh;
            cnt_d    = '0;
            acc_rise = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StIdleHigh: begin
          if (!serial_i) begin
            if (STABLE_CYCLES == 1) begin
              state_d  = StIdleLow;
              acc_fall = 1'b1;
            end else begin
              state_d = StChkLow;
              cnt_d   = CntOne;
            end
          end
        end
        StChkLow: begin
          if (serial_i) begin
            state_d = StIdleHigh;
            cnt_d   = '0;
            abort   = 1'b1;
          end else if (cnt_q == CntLast) begin
            state_d  = StIdleLow;
            cnt_d    = '0;
            acc_fall = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = ResetState;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Filtered level, edge counter and event slot
  always_comb begin
    logic pop, new_evt;
    pop     = evt_valid_q & evt_ready_i;
    new_evt = acc_rise | acc_fall;

    filt_d = filt_q;
    if (acc_rise) filt_d = 1'b1;
    if (acc_fall) filt_d = 1'b0;

    edge_cnt_d = edge_cnt_q;
    if (clr_i) begin
      edge_cnt_d = '0;
    end else if (acc_rise && (edge_cnt_q != CntMax)) begin
      edge_cnt_d = edge_cnt_q + 1'b1;
    end

    evt_valid_d = evt_valid_q;
    evt_rise_d  = evt_rise_q;
    evt_ovf_d   = clr_i ? 1'b0 : evt_ovf_q;
    if (new_evt) begin
      if (!evt_valid_q || pop) begin
        evt_valid_d = 1'b1;
        evt_rise_d  = acc_rise;
      end else begin
        // Slot full and not popped: keep the old event, flag the drop.
        evt_ovf_d = 1'b1;
      end
    end else if (pop) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ResetState;
      cnt_q       <= '0;
      filt_q      <= RESET_LEVEL;
      r_edge_q    <= 1'b0;
      f_edge_q    <= 1'b0;
      edge_cnt_q  <= '0;
      evt_valid_q <= 1'b0;
      evt_rise_q  <= 1'b0;
      evt_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      r_edge_q    <= acc_rise;
      f_edge_q    <= acc_fall;
      edge_cnt_q  <= edge_cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_rise_q  <= evt_rise_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

`ifdef PULP_DEBOUNCE_GLITCH_CNT_EN
  logic [CNT_WIDTH-1:0] glitch_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      glitch_cnt_q <= '0;
    end else if (clr_i) begin
      glitch_cnt_q <= '0;
    end else if (abort && (glitch_cnt_q != CntMax)) begin
      glitch_cnt_q <= glitch_cnt_q + 1'b1;
    end
  end

  assign glitch_cnt_o = glitch_cnt_q;
`endif

  assign filt_o         = filt_q;
  assign r_edge_o       = r_edge_q;
  assign f_edge_o       = f_edge_q;
  assign edge_cnt_o     = edge_cnt_q;
  assign evt_valid_o    = evt_valid_q;
  assign evt_rise_o     = evt_rise_q;
  assign evt_overflow_o = evt_ovf_q;

endmodule
